// File: rtl/paint_ctrl.sv
// Cursor/paint controller for a 2**COORD_W square LED canvas: pointer tracking, single-pixel
// framebuffer writes and palette selection. Define BRUSH_3X3_EN for a clipped 3x3 brush.
module paint_ctrl #(
    parameter int unsigned          COORD_W       = 6,
    parameter int unsigned          COLOR_W       = 8,
    parameter logic [COLOR_W-1:0]   DEFAULT_COLOR = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [2:0]         in_button,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               paint,
    output logic               paleta,
    output logic               selector,
    output logic [COLOR_W-1:0] px_data
);

    typedef enum logic [1:0] {IDLE, TRACK, WRITE, PALETTE} state_t;

    state_t             state_q;
    logic [COORD_W-1:0] xr_q, yr_q, out_x_q, out_y_q, last_x_q, last_y_q;
    logic [2:0]         btn_q, btn_prev_q;
    logic               paint_q, paleta_q, sel_q;
    logic [COLOR_W-1:0] px_q, colour_q;
    logic               press, moved, do_write;
    logic [2:0]         pal_idx;

    function automatic logic [COLOR_W-1:0] palette_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    palette_rom = 8'h00;
            3'd1:    palette_rom = 8'hE0;
            3'd2:    palette_rom = 8'h1C;
            3'd3:    palette_rom = 8'h03;
            3'd4:    palette_rom = 8'hFC;
            3'd5:    palette_rom = 8'hE3;
            3'd6:    palette_rom = 8'h1F;
            default: palette_rom = 8'hFF;
        endcase
    endfunction

    always_comb begin
        press    = (btn_q != btn_prev_q) && (btn_q != 3'd0);
        moved    = (xr_q != last_x_q) || (yr_q != last_y_q);
        // Held paint re-strokes on motion; erase needs a fresh press.
        do_write = ((btn_q == 3'd4) && (press || moved)) || (press && (btn_q == 3'd1));
        pal_idx  = xr_q[COORD_W-1 -: 3];
    end

`ifdef BRUSH_3X3_EN
    logic [3:0]         cnt_q, first_d, next_d;
    logic [COORD_W-1:0] cx_q, cy_q;

    function automatic logic cell_ok(input int unsigned k, input logic [COORD_W-1:0] cx,
                                     input logic [COORD_W-1:0] cy);
        cell_ok = !((k % 3 == 0) && (cx == '0)) && !((k % 3 == 2) && (cx == '1)) &&
                  !((k / 3 == 0) && (cy == '0)) && !((k / 3 == 2) && (cy == '1));
    endfunction

    function automatic logic [COORD_W-1:0] cell_coord(input int unsigned d,
                                                      input logic [COORD_W-1:0] c);
        cell_coord = c + COORD_W'(d) - COORD_W'(1);
    endfunction

    // Lowest in-canvas cell index >= from, or 9 when the brush footprint is exhausted.
    function automatic logic [3:0] next_cell(input logic [3:0] from,
                                             input logic [COORD_W-1:0] cx,
                                             input logic [COORD_W-1:0] cy);
        next_cell = 4'd9;
        for (int unsigned i = 0; i < 9; i++) begin
            int unsigned k;
            k = 8 - i;
            if ((k >= 32'(from)) && cell_ok(k, cx, cy)) next_cell = 4'(k);
        end
    endfunction

    always_comb begin
        first_d = next_cell(4'd0, xr_q, yr_q);
        next_d  = next_cell(cnt_q + 4'd1, cx_q, cy_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            xr_q       <= '0;
            yr_q       <= '0;
            btn_q      <= '0;
            btn_prev_q <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            paint_q    <= 1'b0;
            paleta_q   <= 1'b0;
            sel_q      <= 1'b0;
            px_q       <= '0;
            colour_q   <= DEFAULT_COLOR;
            last_x_q   <= '0;
            last_y_q   <= '0;
`ifdef BRUSH_3X3_EN
            cnt_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
`endif
        end else begin
            xr_q  <= in_x;
            yr_q  <= in_y;
            btn_q <= in_button;
            // Freezing the edge detector during a write defers any press to the next TRACK cycle.
            if (state_q != WRITE) btn_prev_q <= btn_q;

            if (!init) begin
                state_q  <= IDLE;
                out_x_q  <= '0;
                out_y_q  <= '0;
                paint_q  <= 1'b0;
                paleta_q <= 1'b0;
                sel_q    <= 1'b0;
                px_q     <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= TRACK;
                    TRACK: begin
                        out_x_q <= xr_q;
                        out_y_q <= yr_q;
                        if (do_write) begin
                            state_q  <= WRITE;
                            paint_q  <= 1'b1;
                            sel_q    <= 1'b1;
                            px_q     <= (btn_q == 3'd1) ? '0 : colour_q;
                            last_x_q <= xr_q;
                            last_y_q <= yr_q;
`ifdef BRUSH_3X3_EN
                            cnt_q    <= first_d;
                            cx_q     <= xr_q;
                            cy_q     <= yr_q;
                            out_x_q  <= cell_coord(32'(first_d) % 3, xr_q);
                            out_y_q  <= cell_coord(32'(first_d) / 3, yr_q);
`endif
                        end else if (press && (btn_q == 3'd3)) begin
                            state_q  <= PALETTE;
                            paleta_q <= 1'b1;
                        end
                    end
                    WRITE: begin
`ifdef BRUSH_3X3_EN
                        if (next_d != 4'd9) begin
                            cnt_q   <= next_d;
                            out_x_q <= cell_coord(32'(next_d) % 3, cx_q);
                            out_y_q <= cell_coord(32'(next_d) / 3, cy_q);
                        end else begin
`else
                        begin
`endif
                            state_q <= TRACK;
                            paint_q <= 1'b0;
                            sel_q   <= 1'b0;
                            out_x_q <= xr_q;
                            out_y_q <= yr_q;
                        end
                    end
                    PALETTE: begin
                        out_x_q <= xr_q;
                        out_y_q <= yr_q;
                        if (press && (btn_q == 3'd4)) begin
                            colour_q <= palette_rom(pal_idx);
                            state_q  <= TRACK;
                            paleta_q <= 1'b0;
                        end else if (press && (btn_q == 3'd3)) begin
                            state_q  <= TRACK;
                            paleta_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_x    = out_x_q;
    assign out_y    = out_y_q;
    assign paint    = paint_q;
    assign paleta   = paleta_q;
    assign selector = sel_q;
    assign px_data  = px_q;

endmodule

// File: tb/tb_paint_ctrl.sv
// Bench for paint_ctrl: directed scenarios plus random stimulus against a pixel-queue model.
module tb_paint_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1, init = 1'b0;
    logic [5:0] in_x = '0, in_y = '0;
    logic [2:0] in_button = '0;
    logic [5:0] out_x, out_y;
    logic       paint, paleta, selector;
    logic [7:0] px_data;

    paint_ctrl #(.COORD_W(6), .COLOR_W(8), .DEFAULT_COLOR(8'hFF)) dut (
        .clk(clk), .rst(rst), .init(init), .in_x(in_x), .in_y(in_y), .in_button(in_button),
        .out_x(out_x), .out_y(out_y), .paint(paint), .paleta(paleta), .selector(selector),
        .px_data(px_data)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit started = 1'b0;

    typedef enum {M_IDLE, M_TRACK, M_PAL} mode_t;
    mode_t      m_mode;
    int         rx, ry, rb, pb, lx, ly;
    logic [7:0] colour, wdata;
    int         q_x[$], q_y[$];
    int         e_x, e_y;
    bit         e_paint, e_pal, e_sel;
    logic [7:0] e_px;
    logic [7:0] rom [8] = '{8'h00, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hFF};

    int         pulse_cnt = 0, lp_x = -1, lp_y = -1, lp_d = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        rx = 0; ry = 0; rb = 0; pb = 0; lx = 0; ly = 0;
        colour = 8'hFF; wdata = 8'h00;
        q_x.delete(); q_y.delete();
        e_x = 0; e_y = 0; e_paint = 0; e_pal = 0; e_sel = 0; e_px = 8'h00;
    endtask

    // Pixels a write at (cx,cy) must produce, in strobe order, clipped to the canvas.
    task automatic queue_pixels(input int cx, input int cy);
`ifdef BRUSH_3X3_EN
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (cx + dx >= 0 && cx + dx < 64 && cy + dy >= 0 && cy + dy < 64) begin
                    q_x.push_back(cx + dx);
                    q_y.push_back(cy + dy);
                end
`else
        q_x.push_back(cx);
        q_y.push_back(cy);
`endif
    endtask

    task automatic show_head();
        e_x = q_x[0]; e_y = q_y[0]; e_paint = 1; e_sel = 1; e_px = wdata;
    endtask

    task automatic model_edge(input bit r, input bit en, input int ix, input int iy, input int ib);
        bit wr, pr;
        if (r) begin
            model_reset();
            return;
        end
        wr = (q_x.size() != 0);
        pr = (rb != pb) && (rb != 0);
        if (!en) begin
            m_mode = M_IDLE;
            q_x.delete(); q_y.delete();
            e_x = 0; e_y = 0; e_paint = 0; e_pal = 0; e_sel = 0;
        end else if (wr) begin
            void'(q_x.pop_front());
            void'(q_y.pop_front());
            if (q_x.size() != 0) show_head();
            else begin
                e_paint = 0; e_sel = 0; e_x = rx; e_y = ry;
            end
        end else begin
            case (m_mode)
                M_IDLE: m_mode = M_TRACK;
                M_TRACK: begin
                    e_x = rx; e_y = ry;
                    if ((rb == 4 && (pr || rx != lx || ry != ly)) || (pr && rb == 1)) begin
                        wdata = (rb == 1) ? 8'h00 : colour;
                        lx = rx; ly = ry;
                        queue_pixels(rx, ry);
                        show_head();
                    end else if (pr && rb == 3) begin
                        m_mode = M_PAL; e_pal = 1;
                    end
                end
                default: begin
                    e_x = rx; e_y = ry;
                    if (pr && rb == 4) begin
                        colour = rom[rx / 8]; m_mode = M_TRACK; e_pal = 0;
                    end else if (pr && rb == 3) begin
                        m_mode = M_TRACK; e_pal = 0;
                    end
                end
            endcase
        end
        if (!wr) pb = rb;
        rx = ix; ry = iy; rb = ib;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, init, int'(in_x), int'(in_y), int'(in_button));
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("out_x", int'(out_x), e_x);
            chk("out_y", int'(out_y), e_y);
            chk("paint", int'(paint), int'(e_paint));
            chk("paleta", int'(paleta), int'(e_pal));
            chk("selector", int'(selector), int'(e_sel));
            if (e_paint) chk("px_data", int'(px_data), int'(e_px));
            if (paint) begin
                pulse_cnt++;
                lp_x = int'(out_x); lp_y = int'(out_y); lp_d = int'(px_data);
            end
        end
    end

`ifdef BRUSH_3X3_EN
    localparam int FULL = 9, CORNER = 4, LAST_OFS = 1;
`else
    localparam int FULL = 1, CORNER = 1, LAST_OFS = 0;
`endif

    int  base, found;
    int  btab [10] = '{0, 0, 1, 3, 4, 4, 2, 5, 6, 7};
    int  hold;

    initial begin
        model_reset();
        step();
        started = 1'b1;
        steps(4);
        chk("reset_paint", int'(paint), 0);
        chk("reset_px", int'(px_data), 0);

        rst = 1'b0; init = 1'b1;
        in_x = 6'd2; in_y = 6'd4; in_button = 3'd0;
        base = pulse_cnt;
        steps(4);
        chk("track_x", int'(out_x), 2);
        chk("track_y", int'(out_y), 4);
        chk("track_nopaint", pulse_cnt - base, 0);

        in_x = 6'd5; in_y = 6'd7; in_button = 3'd4;
        base = pulse_cnt;
        steps(14);
        chk("press4_pulses", pulse_cnt - base, FULL);
        chk("press4_x", lp_x, 5 + LAST_OFS);
        chk("press4_y", lp_y, 7 + LAST_OFS);
        chk("press4_data", lp_d, 8'hFF);
        in_x = 6'd6;
        base = pulse_cnt;
        steps(14);
        chk("stroke_pulses", pulse_cnt - base, FULL);
        chk("stroke_x", lp_x, 6 + LAST_OFS);

        in_button = 3'd3;
        base = pulse_cnt;
        steps(3000);
        chk("pal_held", int'(paleta), 1);
        chk("pal_nopaint", pulse_cnt - base, 0);
        in_x = 6'd16; in_y = 6'd9; in_button = 3'd4;
        steps(16);
        chk("pal_exit", int'(paleta), 0);
        chk("pal_colour", lp_d, 8'h1C);
        chk("pal_px_x", lp_x, 16 + LAST_OFS);

        in_button = 3'd0; in_x = 6'd0; in_y = 6'd0;
        steps(3);
        in_button = 3'd1;
        base = pulse_cnt;
        steps(12);
        chk("erase_pulses", pulse_cnt - base, CORNER);
        chk("erase_data", lp_d, 0);
        chk("erase_x", lp_x, LAST_OFS);

        in_button = 3'd0; steps(2);
        in_x = 6'd30; in_y = 6'd30; in_button = 3'd4;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            if (e_paint) found = 1;
        end
        chk("write_seen", found, 1);
        init = 1'b0;
        step();
        chk("abort_paint", int'(paint), 0);
        chk("abort_sel", int'(selector), 0);
        in_button = 3'd0;
        steps(2);
        init = 1'b1;
        steps(3);
        in_button = 3'd3;
        steps(4);
        chk("pal_entered", int'(paleta), 1);
        rst = 1'b1;
        step();
        chk("rst_paleta", int'(paleta), 0);
        chk("rst_paint", int'(paint), 0);
        rst = 1'b0; in_button = 3'd0;
        steps(3);

        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                in_button = 3'(btab[$urandom_range(0, 9)]);
                hold = $urandom_range(1, 8);
                case ($urandom_range(0, 3))
                    0: in_x = 6'd0;
                    1: in_x = 6'd63;
                    default: in_x = 6'($urandom_range(0, 63));
                endcase
                case ($urandom_range(0, 3))
                    0: in_y = 6'd0;
                    1: in_y = 6'd63;
                    default: in_y = 6'($urandom_range(0, 63));
                endcase
            end else begin
                hold--;
                if ($urandom_range(0, 3) == 0) in_x = in_x + 6'd1;
                if ($urandom_range(0, 5) == 0) in_y = in_y - 6'd1;
            end
            init = ($urandom_range(0, 99) >= 3);
            rst  = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
